// File: rtl/timer_pkg.sv
// Shared state encoding and default parameters for the timer responder.
package timer_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles, restarting from zero on clear.
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [7:0] TC = 8'(PRESCALE - 1);

    logic [7:0] r_cnt;
    logic       w_tc;

    assign w_tc   = (r_cnt == TC);
    assign o_tick = i_en && !i_clear && w_tc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_responder.sv
// One-shot tick timer: START loads PERIOD ticks, READY is held once they have elapsed.
//   state   | meaning
//   IDLE    | cleared, waiting for START
//   RUN     | counting ticks down, START/PERIOD ignored
//   DONE    | expired, READY held until RESET or START
module timer_responder
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             i_clk,
    input  logic             i_n_reset,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_ready,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_count
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_load_val;
    logic             w_start_ok;
    logic             w_tick;
    logic             w_last;
    logic             w_tick_clear;
    logic             w_tick_en;

    assign w_start_ok   = i_start && !i_reset;
    assign w_load_val   = (i_period == '0) ? WIDTH'(1) : i_period;
    assign w_last       = w_tick && (r_count == WIDTH'(1));
    // Prescaler only runs in RUN, so every load starts a fresh full tick period
    assign w_tick_en    = (r_state == ST_RUN);
    assign w_tick_clear = (r_state != ST_RUN) || i_reset;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_n_reset),
        .i_clear (w_tick_clear),
        .i_en    (w_tick_en),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        if (!i_reset) begin
            case (r_state)
                ST_IDLE: w_next = w_start_ok ? ST_RUN : ST_IDLE;
                ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
                ST_DONE: w_next = w_start_ok ? ST_RUN : ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_count <= '0;
        end else if (i_reset) begin
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_count <= w_load_val;
                    end
                end
                ST_RUN: begin
                    if (w_tick && (r_count != '0)) begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_count = r_count;
        case (r_state)
            ST_RUN:  o_busy  = 1'b1;
            ST_DONE: o_ready = 1'b1;
            default: ;
        endcase
    end

endmodule
